// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES inverse cipher: one decrypt round per clock, reusing a single
// InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns datapath.
// Round keys are fetched by index from an external, combinational key store.
module aes_inv_cipher_iter #(
  parameter int NR = 10,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [127:0]  in_data,
  output logic [CW-1:0] rk_idx,
  input  logic [127:0]  rk_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [127:0]  out_data,
  output logic          busy
);

  generate
    if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
      $error("aes_inv_cipher_iter: NR must be 10, 12 or 14");
    end
    if ((64'd1 << CW) <= 64'(NR)) begin : g_bad_cw
      $error("aes_inv_cipher_iter: CW too narrow for NR");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [CW-1:0] NR_IDX  = CW'(NR);
  localparam logic [CW-1:0] NR_M1   = CW'(NR - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  // GF(2^8) multiply-by-x modulo the AES polynomial
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
  endfunction

  // General GF(2^8) multiply, shift-and-add
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = p ^ (x & {8{b[i]}});
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (a^127 by repeated square-and-multiply, then square); 0 maps to 0
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    r = a;
    for (int i = 0; i < 6; i++) begin
      r = gf_mul(gf_mul(r, r), a);
    end
    return gf_mul(r, r);
  endfunction

  // Inverse S-box: undo the affine map, then invert in GF(2^8)
  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] t;
    t = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    return gf_inv(t);
  endfunction

  // Row r of the column-major state rotates right by r bytes
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = 128'h0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c - r + 4) % 4)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = 128'h0;
    for (int i = 0; i < 16; i++) begin
      o[127 - 8*i -: 8] = inv_sbox(s[127 - 8*i -: 8]);
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 8*(4*c + 0) -: 8];
      a1 = s[127 - 8*(4*c + 1) -: 8];
      a2 = s[127 - 8*(4*c + 2) -: 8];
      a3 = s[127 - 8*(4*c + 3) -: 8];
      o[127 - 8*(4*c + 0) -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[127 - 8*(4*c + 1) -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[127 - 8*(4*c + 2) -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[127 - 8*(4*c + 3) -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

  state_t         state_r, state_nxt_s;
  logic [CW-1:0]  cnt_r, cnt_nxt_s;
  logic [127:0]   data_r, data_nxt_s;
  logic [127:0]   sub_s, ark_s, imc_s;

  // Shared round datapath; FINAL taps it before InvMixColumns
  always_comb begin
    sub_s = inv_sub_bytes(inv_shift_rows(data_r));
    ark_s = sub_s ^ rk_data;
    imc_s = inv_mix_columns(ark_s);
  end

  // State, round counter and the single 128-bit data register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      data_r  <= 128'h0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      data_r  <= data_nxt_s;
    end
  end

  // Next-state, counter and data update
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    data_nxt_s  = data_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_nxt_s = ROUND;
          cnt_nxt_s   = NR_M1;
          data_nxt_s  = in_data ^ rk_data;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ROUND: begin
        data_nxt_s = imc_s;
        if (cnt_r == CNT_ONE) begin
          state_nxt_s = FINAL;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end
      end
      FINAL: begin
        data_nxt_s  = ark_s;
        state_nxt_s = DONE;
      end
      DONE: begin
        // No same-cycle re-accept: IDLE (and in_ready) starts the cycle after
        if (out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // Handshake, status and key-index decode; rk_idx depends only on state and counter
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    rk_idx    = NR_IDX;
    case (state_r)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        rk_idx   = NR_IDX;
      end
      ROUND: begin
        rk_idx = cnt_r;
      end
      FINAL: begin
        rk_idx = CNT_ZERO;
      end
      DONE: begin
        out_valid = 1'b1;
        rk_idx    = CNT_ZERO;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign out_data = data_r;

endmodule

// File: doc/aes_inv_cipher_iter.md
Name: aes_inv_cipher_iter

Overview:
- Iterative AES inverse-cipher engine. Reuses one decrypt-round datapath (InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns) once per clock, over NR rounds.
- Supports AES-128/192/256 through the NR parameter.
- Uses a valid/ready handshake on both input and output.
- Fetches round keys by index from an external round-key store (key-expansion block / key RAM) that returns the key combinationally in the same cycle.
- Sits between the block-mode controller and the key-expansion block. It replaces the per-round combinational chain with a single-round sequential core.

Parameters:
- NR, 10, number of rounds; legal values 10 (AES-128), 12 (AES-192), 14 (AES-256); any other value is a compile-time error.
- CW, 4, width of the round counter and rk_idx; must satisfy 2^CW > NR.

Ports:
- clk  input  1  sole clock, rising edge.
- reset  input  1  synchronous, active-high.
- in_valid  input  1  ciphertext block valid.
- in_ready  output  1  core can accept a block.
- in_data  input  128  ciphertext, byte 0 in bits [127:120].
- rk_idx  output  CW  round-key index requested this cycle (0..NR).
- rk_data  input  128  round key for rk_idx, valid combinationally in the same cycle.
- out_valid  output  1  plaintext valid.
- out_ready  input  1  downstream accepts plaintext.
- out_data  output  128  plaintext, same byte order as in_data.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: state=IDLE, round counter=0, data register=0, in_ready=1, out_valid=0, out_data=0, busy=0.
- Reset mid-operation: on the next edge the core returns to IDLE, the partial result is discarded, and out_valid drops. No block is emitted afterwards for the aborted input.
- IDLE:
  - in_ready=1, rk_idx=NR.
  - On in_valid & in_ready: data <= in_data ^ rk_data (initial AddRoundKey with key NR); counter <= NR-1; go to ROUND.
- ROUND:
  - in_ready=0, rk_idx=counter.
  - data <= InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(data)), rk_data)).
  - If counter==1: go to FINAL, counter <= 0. Otherwise counter <= counter-1.
  - Runs exactly NR-1 cycles (indices NR-1 down to 1).
- FINAL:
  - rk_idx=0.
  - data <= AddRoundKey(InvSubBytes(InvShiftRows(data)), rk_data), with no InvMixColumns.
  - Go to DONE; out_valid <= 1.
- DONE:
  - out_valid=1, out_data=data, in_ready=0.
  - out_data is stable while out_valid & !out_ready (back-pressure holds indefinitely).
  - On out_ready: out_valid <= 0 and go to IDLE.
  - No input is accepted in the same cycle as the output handshake. in_ready rises the cycle after.
- Latency: accept edge at cycle 0 -> out_valid high from cycle NR+1.
  - Minimum issue interval is NR+2 cycles with out_ready held at 1.
  - That is 12 cycles for NR=10 and 16 cycles for NR=14.
- rk_idx is a pure function of state and counter (no dependence on in_valid). This keeps timing stable for the key store.
- rk_idx is only meaningful while the core is active. In IDLE it is held at NR for the pre-fetch.
- in_data is ignored when in_ready=0. in_valid asserted while busy is not an error; the block waits.
- Sub-blocks are combinational and instantiated once. The state register is the only 128-bit storage.

Test Plan:
- AES-128 (NR=10), key 000102030405060708090a0b0c0d0e0f expanded in the bench model; in_data 69c4e0d86a7b0430d8cdb78070b4c55a -> out_data 00112233445566778899aabbccddeeff, out_valid exactly 11 cycles after accept; rk_idx sequence 10,9,...,1,0.
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c; in_data 3925841d02dc09fbdc118597196a0b32 -> 3243f6a8885a308d313198a2e0370734; then hold out_ready=0 for 5 cycles -> out_data stable, in_ready=0 throughout.
- NR=12, key 000102...1617; in_data dda97ca4864cdfe06eaf70a0ec0d7191 -> 00112233445566778899aabbccddeeff, out_valid 13 cycles after accept. NR=14, key 000102...1e1f; in_data 8ea2b7ca516745bfeafc49904b496089 -> same plaintext, 15 cycles after accept.
- Back-to-back: in_valid held high with two ciphertexts and out_ready=1 -> second accept occurs exactly NR+2 cycles after the first; both plaintexts are correct and in order.
- Reset asserted for 1 cycle at ROUND counter=5 -> next cycle busy=0, in_ready=1, out_valid=0. A fresh block then decrypts correctly with no spurious out_valid.
- in_valid pulsed while busy with a different block -> block ignored, exactly one output emitted.
